set_bit_scanner: RTL and testbench

//  Streaming set-bit iterator, successor to the combinational zero-count blocks.

---
 rtl/set_bit_scanner_pkg.sv | 14 +
 rtl/set_bit_scanner_finder.sv | 52 +++++
 rtl/set_bit_scanner.sv | 115 +++++++++++
 tb/tb_set_bit_scanner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/set_bit_scanner_pkg.sv
// Shared types and constants for the streaming set-bit scanner.
// The FSM state type and the scan-order encoding live here so every file agrees on them.
package set_bit_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_e;

  localparam logic MODE_LSB = 1'b0;
  localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/set_bit_scanner_finder.sv
// Combinational locator for the first set bit of a vector, scanning from either end.
// Also reports the isolated one-hot bit and whether exactly one bit is set.
module bit_index_finder #(
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] vec,
  input  logic                  msb_first,
  output logic [IDX_W-1:0]      idx,
  output logic [DATA_WIDTH-1:0] onehot,
  output logic                  single
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] w_rev;
  logic [DATA_WIDTH-1:0] w_sel;
  logic [DATA_WIDTH-1:0] w_lsb;
  logic [DATA_WIDTH-1:0] w_lsb_rev;

  always_comb begin
    w_rev = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_rev[i] = vec[DATA_WIDTH-1-i];
    end
  end

  // MSB-first reuses the two's-complement lowest-bit trick on the mirrored vector.
  assign w_sel = msb_first ? w_rev : vec;
  assign w_lsb = w_sel & (~w_sel + ONE);

  always_comb begin
    w_lsb_rev = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_lsb_rev[i] = w_lsb[DATA_WIDTH-1-i];
    end
  end

  assign onehot = msb_first ? w_lsb_rev : w_lsb;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

  assign single = (vec != '0) && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/set_bit_scanner.sv
// Streaming set-bit iterator: accepts a word and emits one beat per set bit, LSB- or MSB-first.
// A zero word produces a single flagged beat; the next word can load on the final handshake.
module set_bit_scanner
  import set_bit_scanner_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_msb_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [IDX_W-1:0]      out_ord,
  output logic                  out_last,
  output logic                  out_zero
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_residue;
  logic [DATA_WIDTH-1:0] w_residue_nxt;
  logic [IDX_W-1:0]      r_ord;
  logic [IDX_W-1:0]      w_ord_nxt;
  logic                  r_mode;
  logic                  w_mode_nxt;

  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_onehot;
  logic                  w_single;
  logic                  w_fire;
  logic                  w_accept;

  bit_index_finder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_finder (
    .vec      (r_residue),
    .msb_first(r_mode == MODE_MSB),
    .idx      (w_idx),
    .onehot   (w_onehot),
    .single   (w_single)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_residue <= '0;
      r_ord     <= '0;
      r_mode    <= MODE_LSB;
    end else begin
      r_state   <= w_state_nxt;
      r_residue <= w_residue_nxt;
      r_ord     <= w_ord_nxt;
      r_mode    <= w_mode_nxt;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_ord   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    case (r_state)
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = w_idx;
        out_ord   = r_ord;
        out_last  = w_single;
      end
      ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_zero  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_fire   = out_valid & out_ready;
  assign in_ready = (r_state == IDLE) | (w_fire & out_last);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_residue_nxt = r_residue;
    w_ord_nxt     = r_ord;
    w_mode_nxt    = r_mode;
    case (r_state)
      SCAN: begin
        if (w_fire) begin
          w_residue_nxt = r_residue & ~w_onehot;
          w_ord_nxt     = r_ord + IDX_W'(1);
          if (w_single) w_state_nxt = IDLE;
        end
      end
      ZERO: begin
        if (w_fire) w_state_nxt = IDLE;
      end
      default: ;
    endcase
    // Loading after the case lets an accept on the final beat override the return to IDLE.
    if (w_accept) begin
      w_residue_nxt = in_data;
      w_mode_nxt    = in_msb_first;
      w_ord_nxt     = '0;
      w_state_nxt   = (in_data != '0) ? SCAN : ZERO;
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Self-checking bench for set_bit_scanner (DATA_WIDTH=8): directed cases plus random traffic
// compared against a queue of expected beats built from the word's set-bit positions.
module tb_set_bit_scanner;

  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_msb_first;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [IW-1:0] out_ord;
  logic          out_last;
  logic          out_zero;

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_ready = 1'b0;
  bit accepted  = 1'b0;

  typedef struct {
    int idx;
    int ord;
    bit last;
    bit zero;
  } beat_t;

  beat_t q[$];

  set_bit_scanner #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_msb_first(in_msb_first),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_ord     (out_ord),
    .out_last    (out_last),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_load(input logic [DW-1:0] d, input logic msb);
    int pos[$];
    if (msb) begin
      for (int i = DW - 1; i >= 0; i--) if (d[i]) pos.push_back(i);
    end else begin
      for (int i = 0; i < DW; i++) if (d[i]) pos.push_back(i);
    end
    if (pos.size() == 0) begin
      q.push_back('{idx: 0, ord: 0, last: 1'b1, zero: 1'b1});
    end else begin
      foreach (pos[k]) q.push_back('{idx: pos[k], ord: k, last: (k == pos.size() - 1), zero: 1'b0});
    end
  endfunction

  task automatic step();
    bit fire;
    bit acc;
    bit exp_rdy;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1);
    if (!reset) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (q.size() != 0) begin
        check("out_idx", 32'(out_idx), 32'(q[0].idx));
        check("out_ord", 32'(out_ord), 32'(q[0].ord));
        check("out_last", 32'(out_last), 32'(q[0].last));
        check("out_zero", 32'(out_zero), 32'(q[0].zero));
      end
    end
    fire = (q.size() != 0) && out_ready;
    acc  = in_valid && exp_rdy;
    @(posedge clk);
    if (reset) begin
      q.delete();
      accepted = 1'b0;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) model_load(in_data, in_msb_first);
      accepted = acc;
    end
    #1;
  endtask

  task automatic idle_outputs_check();
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_idx", 32'(out_idx), 32'd0);
    check("idle_ord", 32'(out_ord), 32'd0);
    check("idle_last", 32'(out_last), 32'd0);
    check("idle_zero", 32'(out_zero), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid asserted so a following call can land on the last-beat handshake.
  task automatic send_word(input logic [DW-1:0] d, input logic msb);
    in_valid     = 1'b1;
    in_data      = d;
    in_msb_first = msb;
    for (int n = 0; n < 100; n++) begin
      step();
      if (accepted) break;
    end
    check("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 200 && q.size() != 0; n++) step();
    check("drain_timeout", 32'(q.size()), 32'd0);
    step();
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_msb_first = 1'b0;
    out_ready    = 1'b0;
    step();
    step();
    idle_outputs_check();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();

    send_word(8'hA4, 1'b0);
    drain();
    send_word(8'hA4, 1'b1);
    drain();
    send_word(8'hFF, 1'b0);
    drain();
    send_word(8'h00, 1'b0);
    drain();
    idle_outputs_check();

    rnd_ready = 1'b1;
    send_word(8'h66, 1'b0);
    drain();
    send_word(8'h66, 1'b1);
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    send_word(8'h01, 1'b0);
    send_word(8'h80, 1'b0);
    send_word(8'h00, 1'b1);
    send_word(8'h81, 1'b1);
    drain();

    send_word(8'hFF, 1'b0);
    in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_outputs_check();
    step();
    send_word(8'h10, 1'b0);
    drain();

    rnd_ready = 1'b1;
    for (int t = 0; t < 250; t++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = '1;
        default: d = DW'($urandom);
      endcase
      send_word(d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) step();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
